pipe_if: RTL

//  Instruction-fetch stage plus IF/ID pipeline register of the 54-instruction MIPS pipeline CPU.

---
 rtl/pipe_if.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pipe_if.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, handshakes a
// variable-latency instruction memory, and applies decode redirects after one delay slot.
module pipe_if #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [2:0]  id_pc_mux_sel,
  input  logic [31:0] id_b_pc,
  input  logic [31:0] id_j_pc,
  input  logic [31:0] id_r_pc,
  input  logic [31:0] id_cp0_pc,
  input  logic [31:0] id_pc4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc4,
  output logic        if_valid
);

  typedef enum logic {S_FETCH, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic        r_pend;
  logic [31:0] r_ptgt;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc4;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc4;
  logic        r_if_valid;

  logic        w_fetch_ack;
  logic        w_redirect;
  logic [31:0] w_tgt;
  logic        w_take_now;
  logic        w_set_pend;
  logic        w_pc_ld;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FETCH: if (imem_ack && stall) w_state_nxt = S_HOLD;
      S_HOLD:  if (!stall)            w_state_nxt = S_FETCH;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    imem_req    = (r_state == S_FETCH) && !rst;
    w_fetch_ack = (r_state == S_FETCH) && imem_ack;
  end

  always_comb begin
    w_tgt = id_b_pc;
    unique case (id_pc_mux_sel)
      3'd1:    w_tgt = id_b_pc;
      3'd2:    w_tgt = id_j_pc;
      3'd3:    w_tgt = id_r_pc;
      3'd4:    w_tgt = id_cp0_pc;
      default: w_tgt = id_b_pc;
    endcase
  end

  // A redirect lands in the PC now only if the delay slot is fetched this cycle or
  // already sits in the skid; otherwise it is parked until the delay slot's ack.
  always_comb begin
    w_redirect = !stall && r_if_valid && (id_pc_mux_sel inside {[3'd1:3'd4]});
    w_take_now = w_redirect &&
                 (w_fetch_ack || ((r_state == S_HOLD) && (r_pc != id_pc4)));
    w_set_pend = w_redirect && !w_take_now;
    w_pc_plus4 = r_pc + 32'd4;
    w_pc_ld    = w_fetch_ack || w_take_now;
    if (w_take_now)  w_pc_nxt = w_tgt;
    else if (r_pend) w_pc_nxt = r_ptgt;
    else             w_pc_nxt = w_pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_pend <= 1'b0;
      r_ptgt <= '0;
    end else begin
      if (w_pc_ld) r_pc <= w_pc_nxt;
      if (w_set_pend) begin
        r_pend <= 1'b1;
        r_ptgt <= w_tgt;
      end else if (w_fetch_ack) begin
        r_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_instr   <= NOP_WORD;
      r_if_pc4     <= '0;
      r_if_valid   <= 1'b0;
      r_skid_instr <= NOP_WORD;
      r_skid_pc4   <= '0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            if (!stall) begin
              r_if_instr <= imem_rdata;
              r_if_pc4   <= w_pc_plus4;
              r_if_valid <= 1'b1;
            end else begin
              r_skid_instr <= imem_rdata;
              r_skid_pc4   <= w_pc_plus4;
            end
          end else if (!stall) begin
            r_if_instr <= NOP_WORD;
            r_if_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_if_instr <= r_skid_instr;
            r_if_pc4   <= r_skid_pc4;
            r_if_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr      = r_pc;
  assign if_instruction = r_if_instr;
  assign if_pc4         = r_if_pc4;
  assign if_valid       = r_if_valid;

endmodule
